// File: rtl/dct_transpose_8x8_if.sv
// Row-in / column-out stream bundle for the 8x8 transpose buffer.
// Slave is the buffer itself; master is whoever drives rows and drains columns.
interface dct_transpose_8x8_if #(
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH*8-1:0] in_data;
    logic                    in_valid;
    logic                    in_ready;
    logic [DATA_WIDTH*8-1:0] out_data;
    logic                    out_valid;
    logic                    out_ready;
    logic [2:0]              out_col;
    logic                    out_last;

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready,
        output out_data,
        output out_valid,
        input  out_ready,
        output out_col,
        output out_last
    );

    modport master (
        output in_data,
        output in_valid,
        input  in_ready,
        input  out_data,
        input  out_valid,
        output out_ready,
        input  out_col,
        input  out_last
    );
endinterface

// File: rtl/dct_transpose_8x8.sv
// Ping-pong 8x8 transpose buffer between the row and column DCT passes.
// One bank fills row by row while the other drains column by column.
module dct_transpose_8x8 #(
    parameter int DATA_WIDTH = 32
) (
    input logic                  clk,
    input logic                  reset,
    dct_transpose_8x8_if.slave   bus
);
    logic [DATA_WIDTH-1:0] mem [2][8][8];

    logic       wr_bank;
    logic [2:0] wr_row;
    logic       rd_bank;
    logic [2:0] rd_col;
    logic [1:0] full;
    logic [1:0] full_nxt;
    logic       wr_en;
    logic       rd_en;

    assign bus.in_ready  = !full[wr_bank];
    assign bus.out_valid = full[rd_bank];
    assign bus.out_col   = rd_col;
    assign bus.out_last  = full[rd_bank] && (rd_col == 3'd7);

    assign wr_en = bus.in_valid && !full[wr_bank];
    assign rd_en = bus.out_ready && full[rd_bank];

    always_comb begin
        for (int k = 0; k < 8; k++) begin
            bus.out_data[k*DATA_WIDTH +: DATA_WIDTH] = mem[rd_bank][k][rd_col];
        end
    end

    // Set and clear never hit the same bit: write needs the bank empty, read needs it full.
    always_comb begin
        full_nxt = full;
        if (wr_en && wr_row == 3'd7) begin
            full_nxt[wr_bank] = 1'b1;
        end
        if (rd_en && rd_col == 3'd7) begin
            full_nxt[rd_bank] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int j = 0; j < 8; j++) begin
                mem[wr_bank][wr_row][j] <= bus.in_data[j*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_bank <= 1'b0;
            wr_row  <= 3'd0;
            rd_bank <= 1'b0;
            rd_col  <= 3'd0;
            full    <= 2'b00;
        end else begin
            full <= full_nxt;
            if (wr_en) begin
                wr_row <= wr_row + 3'd1;
                if (wr_row == 3'd7) begin
                    wr_bank <= ~wr_bank;
                end
            end
            if (rd_en) begin
                rd_col <= rd_col + 3'd1;
                if (rd_col == 3'd7) begin
                    rd_bank <= ~rd_bank;
                end
            end
        end
    end
endmodule
